// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for the fetch side of the MIPS-Lite pipeline.
//   Requests are accepted over a valid/ready handshake. The memory word is read
//   at the accept edge and delayed through a LATENCY-deep pipeline. It is then
//   written into an in-order response FIFO. A registered outstanding count
//   (credits) limits accepted-but-not-handed-off requests to QDEPTH, so the
//   FIFO can never overflow.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   req_valid  : fetch request present          req_ready : credit available
//   req_pc     : byte address to fetch
//   rsp_valid  : FIFO head holds a response     rsp_ready : fetch takes it
//   rsp_instr  : instruction word (0 on error or when the FIFO is empty)
//   rsp_pc     : pc echoed from the request
//   rsp_err    : misaligned or out-of-range request
//   load_en/load_addr/load_data : program-load write port
//   busy       : at least one request outstanding
// -----------------------------------------------------------------------------
module imem_responder #(
   parameter int ADDRESSWIDTH = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int LATENCY      = 2,
   parameter int QDEPTH       = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [ADDRESSWIDTH-1:0]        req_pc,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [31:0]                    rsp_instr,
   output logic [ADDRESSWIDTH-1:0]        rsp_pc,
   output logic                           rsp_err,
   input  logic                           load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
   input  logic [31:0]                    load_data,
   output logic                           busy
);

   localparam int LAW = $clog2(DEPTH_WORDS);
   localparam int IW  = ADDRESSWIDTH - 2;
   localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW  = $clog2(QDEPTH + 1);
   localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

   typedef struct packed {
      logic [31:0]             instr;
      logic [ADDRESSWIDTH-1:0] pc;
      logic                    err;
   } rsp_t;

   // ---------------------------------------------------------------- memory
   // No reset: program contents survive a pipeline reset.
   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] ld_idx;

   assign ld_idx = 32'(load_addr);

   always_ff @(posedge clk) begin
      if (load_en && (ld_idx < DEPTH_U))
         mem_q[load_addr] <= load_data;
   end

   // ---------------------------------------------------------------- accept
   logic          accept, hand;
   logic [IW-1:0] idx;
   logic          bad;
   logic [31:0]   rd_word;
   rsp_t          new_ent;

   assign accept = req_valid && req_ready;
   assign hand   = rsp_valid && rsp_ready;
   assign idx    = req_pc[ADDRESSWIDTH-1:2];
   // Out-of-range indices are flagged here, so a truncated index into the
   // array never produces a word that reaches the response.
   assign bad    = (|req_pc[1:0]) || (idx >= IW'(DEPTH_WORDS));
   // Combinational read ahead of the edge gives read-before-write against a
   // load to the same word at the accept edge.
   assign rd_word = mem_q[idx[LAW-1:0]];

   always_comb begin
      new_ent.pc    = req_pc;
      new_ent.err   = bad;
      new_ent.instr = bad ? 32'h0 : rd_word;
   end

   // ---------------------------------------------------------------- latency
   // The FIFO write happens at edge k+LATENCY-1 for an accept at edge k.
   // That means LATENCY-1 register stages between the read and the FIFO.
   logic wr_vld;
   rsp_t wr_ent;

   generate
      if (LATENCY == 1) begin : g_lat1
         assign wr_vld = accept;
         assign wr_ent = new_ent;
      end else begin : g_latn
         rsp_t                 pipe_q [LATENCY-1];
         logic [LATENCY-2:0]   pvld_q;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               pvld_q <= '0;
               for (int i = 0; i < LATENCY-1; i++) pipe_q[i] <= '0;
            end else begin
               pvld_q[0] <= accept;
               pipe_q[0] <= new_ent;
               for (int i = 1; i < LATENCY-1; i++) begin
                  pvld_q[i] <= pvld_q[i-1];
                  pipe_q[i] <= pipe_q[i-1];
               end
            end
         end

         assign wr_vld = pvld_q[LATENCY-2];
         assign wr_ent = pipe_q[LATENCY-2];
      end
   endgenerate

   // ---------------------------------------------------------------- credits
   logic [CW-1:0] osd_q, osd_d;

   always_comb begin
      osd_d = osd_q;
      case ({accept, hand})
         2'b10:   osd_d = osd_q + CW'(1);
         2'b01:   osd_d = osd_q - CW'(1);
         default: osd_d = osd_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) osd_q <= '0;
      else       osd_q <= osd_d;
   end

   // Gated by reset so no request is accepted while the block is held.
   assign req_ready = !reset && (osd_q < CW'(QDEPTH));
   assign busy      = (osd_q != '0);

   // ---------------------------------------------------------------- FIFO
   rsp_t          fifo_q [QDEPTH];
   logic [PW-1:0] wptr_q, rptr_q, wptr_d, rptr_d;
   logic [CW-1:0] fcnt_q, fcnt_d;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      fcnt_d = fcnt_q;
      if (wr_vld)
         wptr_d = (wptr_q == PW'(QDEPTH-1)) ? '0 : wptr_q + PW'(1);
      if (hand)
         rptr_d = (rptr_q == PW'(QDEPTH-1)) ? '0 : rptr_q + PW'(1);
      case ({wr_vld, hand})
         2'b10:   fcnt_d = fcnt_q + CW'(1);
         2'b01:   fcnt_d = fcnt_q - CW'(1);
         default: fcnt_d = fcnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         fcnt_q <= '0;
         for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         fcnt_q <= fcnt_d;
         if (wr_vld) fifo_q[wptr_q] <= wr_ent;
      end
   end

   // ---------------------------------------------------------------- outputs
   rsp_t head;

   assign rsp_valid = (fcnt_q != '0);
   assign head      = rsp_valid ? fifo_q[rptr_q] : '0;
   assign rsp_instr = head.instr;
   assign rsp_pc    = head.pc;
   assign rsp_err   = head.err;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Directed bench for imem_responder. A reference model keeps a shadow memory
//   and a queue of expected responses stamped with the cycle they may first be
//   seen. It checks every DUT output on each falling edge. Directed tasks pin
//   hand-computed literal values on top of that.
// -----------------------------------------------------------------------------
module tb_imem_responder;

   localparam int AW  = 32;
   localparam int DW  = 1024;
   localparam int LAT = 2;
   localparam int QD  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0, req_ready;
   logic [AW-1:0] req_pc = '0;
   logic          rsp_valid, rsp_ready = 1'b0;
   logic [31:0]   rsp_instr;
   logic [AW-1:0] rsp_pc;
   logic          rsp_err;
   logic          load_en = 1'b0;
   logic [9:0]    load_addr = '0;
   logic [31:0]   load_data = '0;
   logic          busy;

   imem_responder #(.ADDRESSWIDTH(AW), .DEPTH_WORDS(DW), .LATENCY(LAT), .QDEPTH(QD)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_err(rsp_err),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        err;
      int          rdy;   // first cycle the response may be visible
   } exp_t;

   exp_t        q[$];
   logic [31:0] mmem [DW];
   int          cyc = 0;

   initial for (int i = 0; i < DW; i++) mmem[i] = '0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      logic ev, acc;
      int   wi;
      if (reset) begin
         q.delete();
         chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
         chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
         chk("rst_busy", {31'b0, busy}, 32'd0);
         chk("rst_rsp_instr", rsp_instr, 32'd0);
         chk("rst_rsp_pc", rsp_pc, 32'd0);
         chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      end else begin
         ev = (q.size() > 0) && (q[0].rdy <= cyc);
         chk("m_rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
         chk("m_req_ready", {31'b0, req_ready}, {31'b0, q.size() < QD});
         chk("m_busy", {31'b0, busy}, {31'b0, q.size() != 0});
         if (ev) begin
            chk("m_rsp_instr", rsp_instr, q[0].instr);
            chk("m_rsp_pc", rsp_pc, q[0].pc);
            chk("m_rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
         end else begin
            chk("m_idle_instr", rsp_instr, 32'd0);
            chk("m_idle_pc", rsp_pc, 32'd0);
            chk("m_idle_err", {31'b0, rsp_err}, 32'd0);
         end
         acc = req_valid && (q.size() < QD);
         if (ev && rsp_ready) void'(q.pop_front());
         if (acc) begin
            wi      = int'(req_pc >> 2);
            e.pc    = req_pc;
            e.err   = (req_pc[1:0] != 2'b00) || (wi >= DW);
            e.instr = e.err ? 32'h0 : mmem[wi];
            e.rdy   = cyc + LAT;
            q.push_back(e);
         end
         // The read above sees the old word; the load lands afterwards.
         if (load_en) mmem[load_addr] = load_data;
      end
   end

   // ---------------------------------------------------------------- tasks
   task automatic load(input int a, input logic [31:0] d);
      @(posedge clk); #1;
      load_en = 1'b1; load_addr = 10'(a); load_data = d;
      @(posedge clk); #1;
      load_en = 1'b0;
   endtask

   // Single request from idle; checks the response literally once visible.
   task automatic fetch1(input string nm, input logic [31:0] pc,
                         input logic [31:0] ei, input logic ee,
                         input logic do_ld, input int la, input logic [31:0] ld);
      @(posedge clk); #1;
      req_valid = 1'b1; req_pc = pc; rsp_ready = 1'b1;
      if (do_ld) begin load_en = 1'b1; load_addr = 10'(la); load_data = ld; end
      @(posedge clk); #1;              // accept edge
      req_valid = 1'b0; load_en = 1'b0;
      if (LAT > 1) chk({nm, "_early"}, {31'b0, rsp_valid}, 32'd0);
      repeat (LAT-1) @(posedge clk);
      #1;
      chk({nm, "_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({nm, "_instr"}, rsp_instr, ei);
      chk({nm, "_pc"}, rsp_pc, pc);
      chk({nm, "_err"}, {31'b0, rsp_err}, {31'b0, ee});
      @(posedge clk); #1;
   endtask

   // ---------------------------------------------------------------- stimulus
   logic [31:0] words [4];
   initial begin
      int j, acc, seen;
      words[0] = 32'h2001_0005; words[1] = 32'h2002_000A;
      words[2] = 32'h0022_1820; words[3] = 32'hAC03_0000;

      // Reset then idle
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
      chk("idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);

      // Program load and single fetch
      for (int i = 0; i < 4; i++) load(i, words[i]);
      fetch1("single", 32'h8, 32'h0022_1820, 1'b0, 1'b0, 0, 32'h0);

      // Back-to-back streaming
      j = 0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 4 + LAT + 2; c++) begin
         @(posedge clk); #1;
         if (c < 4) begin req_valid = 1'b1; req_pc = 32'(4*c); end
         else req_valid = 1'b0;
         #2;
         if (c < 4) chk("stream_req_ready", {31'b0, req_ready}, 32'd1);
         if (rsp_valid) begin
            if (j < 4) chk("stream_word", rsp_instr, words[j]);
            j++;
         end
      end
      chk("stream_count", 32'(j), 32'd4);

      // Backpressure / credits
      rsp_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_pc = 32'(4*(c%4));
         #2;
         if (req_ready) acc++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_accepts", 32'(acc), 32'd4);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("bp_hold_pc", rsp_pc, 32'h0);
         chk("bp_hold_instr", rsp_instr, words[0]);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;              // first handoff edge
      chk("bp_ready_back", {31'b0, req_ready}, 32'd1);
      chk("bp_next_pc", rsp_pc, 32'h4);
      repeat (5) @(posedge clk);
      #1 chk("bp_drained", {31'b0, busy}, 32'd0);

      // Errors
      fetch1("misalign", 32'h6, 32'h0, 1'b1, 1'b0, 0, 32'h0);
      fetch1("range", 32'h1000, 32'h0, 1'b1, 1'b0, 0, 32'h0);
      fetch1("after_err", 32'h4, 32'h2002_000A, 1'b0, 1'b0, 0, 32'h0);

      // Read/write collision on the same word at the same edge
      fetch1("collide", 32'h4, 32'h2002_000A, 1'b0, 1'b1, 1, 32'hDEAD_BEEF);
      fetch1("refetch", 32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 32'h0);

      // Reset with requests outstanding
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_pc = 32'(4*c);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("async_req_ready", {31'b0, req_ready}, 32'd0);
      chk("async_busy", {31'b0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0; rsp_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      chk("post_reset_none", 32'(seen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the fetch side of the MIPS-Lite pipeline; services instruction requests from the fetch stage.
- Returns 32-bit instruction words in order, with a fixed access latency, over valid/ready handshakes.
- Includes a program-load write port for the bench or loader, plus credit-based flow control so the fetch stage can stall on rsp_ready.

Parameters:
- ADDRESSWIDTH, 32, byte-address width of req_pc and rsp_pc (mips_pkg value).
- DEPTH_WORDS, 1024, number of 32-bit words in the memory array.
- LATENCY, 2, cycles from request acceptance to response visibility; legal 1..4.
- QDEPTH, 4, maximum outstanding requests (accepted but not yet handed off); must be >= 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch stage presents a request.
- req_ready  out  1  responder can accept a request.
- req_pc  in  ADDRESSWIDTH  byte address to fetch.
- rsp_valid  out  1  response available at the FIFO head.
- rsp_ready  in  1  fetch stage takes the response.
- rsp_instr  out  32  instruction word (Instruct encoding).
- rsp_pc  out  ADDRESSWIDTH  pc of the request this response answers.
- rsp_err  out  1  request was misaligned or out of range.
- load_en  in  1  write strobe for program load.
- load_addr  in  $clog2(DEPTH_WORDS)  word index to write.
- load_data  in  32  word to write.
- busy  out  1  at least one request outstanding.

Behaviour:
- Reset is asynchronous and active-high.
  - While reset is high: req_ready=0, rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_err=0, busy=0.
  - Outstanding count, latency pipeline and response FIFO are all cleared.
  - Memory contents are NOT cleared.
- Reset asserted mid-operation drops every in-flight and queued response; none are ever delivered.
- Accept: a request is accepted when req_valid && req_ready at a clk edge. req_pc is captured and memory is read at that edge.
- req_ready = (outstanding < QDEPTH), where outstanding is a registered count.
  - Increment on accept only; decrement on rsp handshake only (rsp_valid && rsp_ready).
  - Accept and handoff in the same edge leave the count unchanged.
- busy = (outstanding != 0).
- Word index = req_pc[ADDRESSWIDTH-1:2].
  - req_pc[1:0] != 0: rsp_err=1 and rsp_instr=32'h0 (NOP).
  - Index >= DEPTH_WORDS: rsp_err=1 and rsp_instr=32'h0.
  - Otherwise rsp_err=0 and rsp_instr=mem[index].
  - rsp_pc always echoes req_pc.
- Latency:
  - A request accepted at edge k is written into the response FIFO so that rsp_valid can first be high in the cycle after edge k+LATENCY-1.
  - LATENCY=1 means visible in the cycle right after acceptance.
  - The FIFO never overflows because it is credit-limited by QDEPTH.
- Ordering: responses leave strictly in acceptance order.
- rsp_* are driven from the FIFO head and hold stable while rsp_valid && !rsp_ready. When the FIFO is empty, rsp_instr, rsp_pc and rsp_err are driven to 0.
- Throughput: with rsp_ready held high and QDEPTH >= LATENCY+1, one request is accepted and one response delivered per cycle.
- Load port:
  - When load_en=1, mem[load_addr] <= load_data at the edge.
  - Writes are legal during outstanding requests.
  - A read and a write to the same word at the same edge is read-before-write: the response carries the old word.
  - load_addr >= DEPTH_WORDS is ignored.
- Wrap-around: a pc with the top bits set maps to index >= DEPTH_WORDS and returns an error. No address aliasing.

Test Plan:
- Reset then idle: hold reset 2 cycles, release. Require req_ready=1, rsp_valid=0, busy=0. Then assert reset while 3 requests are outstanding: rsp_valid=0 immediately (asynchronous), and no response appears after release.
- Load and single fetch: load mem[0..3]=32'h2001_0005, 32'h2002_000A, 32'h0022_1820, 32'hAC03_0000. Request pc=0x8 with rsp_ready=1.
  - Require rsp_valid exactly LATENCY=2 cycles later, rsp_instr=32'h0022_1820, rsp_pc=0x8, rsp_err=0.
- Back-to-back streaming: requests pc=0x0,0x4,0x8,0xC on consecutive cycles with rsp_ready=1.
  - Require 4 consecutive responses in order carrying the loaded words, and req_ready never low.
- Backpressure/credits: rsp_ready=0 with continuous requests.
  - Require exactly 4 (QDEPTH) accepts, then req_ready=0. rsp_* stay at pc=0x0 while stalled.
  - Raise rsp_ready: one response per cycle, and req_ready returns in the same cycle as the first handoff.
- Errors: request pc=0x6 gives rsp_err=1 and rsp_instr=0. Request pc=0x1000 (index 1024) gives rsp_err=1 and rsp_instr=0. A following pc=0x4 returns 32'h2002_000A with rsp_err=0.
- Read/write collision: load_en writing mem[1]=32'hDEAD_BEEF on the same edge that pc=0x4 is accepted.
  - Require rsp_instr=32'h2002_000A; the next fetch of pc=0x4 returns 32'hDEAD_BEEF.
